// File: rtl/fc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fc_seq_ctrl
// Purpose  : Load, compute and write-back sequencer for one FC layer pass.
// Revision : 1.0
// ============================================================================
module fc_seq_ctrl #(
  parameter int NUM_IN   = 120,
  parameter int NUM_OUT  = 84,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 14,
  parameter int IN_BASE  = 0,
  parameter int W_BASE   = 120,
  parameter int B_BASE   = 10200,
  parameter int OUT_BASE = 10284,
  parameter int ROW_W    = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     finished,
  output logic [ADDR_W-1:0]        mem_address,
  output logic                     mem_read_enable,
  output logic                     mem_write_enable,
  output logic [DATA_W-1:0]        mem_data_in,
  input  logic [NUM_IN*DATA_W-1:0] mem_data_out,
  output logic                     ld_valid,
  output logic [1:0]               ld_sel,
  output logic [ROW_W-1:0]         ld_row,
  output logic [NUM_IN*DATA_W-1:0] ld_data,
  output logic                     layer_enable,
  input  logic                     layer_finished,
  output logic [ROW_W-1:0]         out_sel,
  input  logic [DATA_W-1:0]        out_value
);

  localparam logic [ADDR_W-1:0] C_IN_BASE  = ADDR_W'(IN_BASE);
  localparam logic [ADDR_W-1:0] C_W_BASE   = ADDR_W'(W_BASE);
  localparam logic [ADDR_W-1:0] C_B_BASE   = ADDR_W'(B_BASE);
  localparam logic [ADDR_W-1:0] C_OUT_BASE = ADDR_W'(OUT_BASE);
  localparam logic [ADDR_W-1:0] C_NUM_IN   = ADDR_W'(NUM_IN);
  localparam logic [ROW_W-1:0]  C_ONE      = ROW_W'(1);
  localparam logic [ROW_W-1:0]  C_NUM_OUT  = ROW_W'(NUM_OUT);
  localparam logic [ROW_W-1:0]  C_LAST_RD  = ROW_W'(NUM_OUT + 1);
  localparam logic [ROW_W-1:0]  C_LAST_WR  = ROW_W'(NUM_OUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_DRAIN   = 3'd2,
    S_COMPUTE = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t           state, state_nx;
  logic [ROW_W-1:0] rd_cnt, wr_cnt;
  logic [1:0]       rd_sel;
  logic [ROW_W-1:0] rd_row;
  logic [ADDR_W-1:0] rd_addr;

  // Read schedule: input row, then NUM_OUT weight rows, then the bias row.
  always_comb begin
    rd_sel  = 2'd0;
    rd_row  = '0;
    rd_addr = C_IN_BASE;
    if (rd_cnt == '0) begin
      rd_sel  = 2'd0;
      rd_addr = C_IN_BASE;
    end else if (rd_cnt <= C_NUM_OUT) begin
      rd_sel  = 2'd1;
      rd_row  = rd_cnt - C_ONE;
      rd_addr = C_W_BASE + ADDR_W'(rd_cnt - C_ONE) * C_NUM_IN;
    end else begin
      rd_sel  = 2'd2;
      rd_addr = C_B_BASE;
    end
  end

  always_comb begin
    state_nx         = state;
    busy             = 1'b1;
    finished         = 1'b0;
    mem_address      = '0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_data_in      = '0;
    layer_enable     = 1'b0;
    out_sel          = '0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = S_READ;
      end
      S_READ: begin
        mem_read_enable = 1'b1;
        mem_address     = rd_addr;
        if (rd_cnt == C_LAST_RD) state_nx = S_DRAIN;
      end
      S_DRAIN: state_nx = S_COMPUTE;
      S_COMPUTE: begin
        layer_enable = 1'b1;
        if (layer_finished) state_nx = S_WRITE;
      end
      S_WRITE: begin
        mem_write_enable = 1'b1;
        out_sel          = wr_cnt;
        mem_address      = C_OUT_BASE + ADDR_W'(wr_cnt);
        mem_data_in      = out_value;
        if (wr_cnt == C_LAST_WR) state_nx = S_DONE;
      end
      S_DONE: begin
        finished = 1'b1;
        state_nx = S_IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = S_IDLE;
      end
    endcase
  end

  // Load strobe and target trail the read by one cycle, alongside the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      ld_valid <= 1'b0;
      ld_sel   <= 2'd0;
      ld_row   <= '0;
      ld_data  <= '0;
    end else begin
      state    <= state_nx;
      rd_cnt   <= (state == S_READ)  ? rd_cnt + C_ONE : '0;
      wr_cnt   <= (state == S_WRITE) ? wr_cnt + C_ONE : '0;
      ld_valid <= (state == S_READ);
      ld_sel   <= (state == S_READ)  ? rd_sel : 2'd0;
      ld_row   <= (state == S_READ)  ? rd_row : '0;
      if (state == S_READ) ld_data <= mem_data_out;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_seq_ctrl
// Purpose  : Scoreboard bench for fc_seq_ctrl load/compute/write-back passes.
// Revision : 1.0
// ============================================================================
module tb_fc_seq_ctrl;
  localparam int NUM_IN  = 120;
  localparam int NUM_OUT = 84;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 14;
  localparam int ROW_W   = 7;
  localparam int WW      = NUM_IN * DATA_W;

  logic              clk = 1'b0;
  logic              rst, start, layer_finished;
  logic              busy, finished, mem_read_enable, mem_write_enable;
  logic              ld_valid, layer_enable;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in, out_value;
  logic [WW-1:0]     mem_data_out, ld_data;
  logic [1:0]        ld_sel;
  logic [ROW_W-1:0]  ld_row, out_sel;

  fc_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .finished(finished),
    .mem_address(mem_address), .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .ld_valid(ld_valid), .ld_sel(ld_sel),
    .ld_row(ld_row), .ld_data(ld_data), .layer_enable(layer_enable),
    .layer_finished(layer_finished), .out_sel(out_sel), .out_value(out_value)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WW-1:0] word_of(input logic [ADDR_W-1:0] a);
    logic [WW-1:0] w;
    for (int j = 0; j < NUM_IN; j++)
      w[j*DATA_W +: DATA_W] = (DATA_W'(a) * 16'd3) ^ DATA_W'(j) ^ 16'h5A00;
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] outval_f(input logic [ROW_W-1:0] k);
    return 16'hC000 | (DATA_W'(k) * 16'd37);
  endfunction

  assign mem_data_out = mem_read_enable ? word_of(mem_address) : '0;
  assign out_value    = outval_f(out_sel);

  typedef struct packed {
    logic [1:0]        sel;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr;
  } ld_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic [ADDR_W-1:0] exp_rd[$];
  ld_t               exp_ld[$];
  wr_t               exp_wr[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Per-pass observations gathered by the monitor
  int   st_rd, st_ld, st_wr, st_en, st_fin;
  int   first_busy, first_rd, first_ld, first_en, last_en, first_wr, fin_cyc;
  logic busy_q = 1'b0;
  logic [ADDR_W-1:0] m_a;
  ld_t  m_l;
  wr_t  m_w;

  always @(negedge clk) begin
    if (mem_read_enable || mem_write_enable)
      chk("rd_wr_exclusive", 64'(mem_read_enable & mem_write_enable), 64'd0);
    if (busy && !busy_q) first_busy = cyc;
    busy_q = busy;
    if (mem_read_enable) begin
      if (st_rd == 0) first_rd = cyc;
      st_rd++;
      if (exp_rd.size() == 0) fail_now("unexpected_read");
      else begin
        m_a = exp_rd.pop_front();
        chk("read_addr", 64'(mem_address), 64'(m_a));
      end
    end
    if (ld_valid) begin
      if (st_ld == 0) first_ld = cyc;
      st_ld++;
      if (exp_ld.size() == 0) fail_now("unexpected_load");
      else begin
        m_l = exp_ld.pop_front();
        chk("ld_sel_row", 64'({ld_sel, ld_row}), 64'({m_l.sel, m_l.row}));
        n_checks++;
        if (ld_data !== word_of(m_l.addr)) begin
          n_fail++;
          $display("FAIL ld_data: low word got %0h, expected %0h (cycle %0d)",
                   ld_data[63:0], word_of(m_l.addr) >> 0 & 64'hFFFF_FFFF_FFFF_FFFF, cyc);
        end
      end
    end
    if (mem_write_enable) begin
      if (st_wr == 0) first_wr = cyc;
      st_wr++;
      if (exp_wr.size() == 0) fail_now("unexpected_write");
      else begin
        m_w = exp_wr.pop_front();
        chk("write_addr_data", 64'({mem_address, mem_data_in}), 64'({m_w.addr, m_w.data}));
      end
    end
    if (layer_enable) begin
      if (st_en == 0) first_en = cyc;
      st_en++;
      last_en = cyc;
    end
    if (finished) begin
      st_fin++;
      fin_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    st_rd = 0; st_ld = 0; st_wr = 0; st_en = 0; st_fin = 0;
    first_busy = -1; first_rd = -1; first_ld = -1; first_en = -1;
    last_en = -1; first_wr = -1; fin_cyc = -1;
  endtask

  // Expected pass: input row, 84 weight rows at 120 + i*120, bias row, then 84 writes.
  task automatic push_pass();
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < NUM_OUT + 2; i++) begin
      if (i == 0) begin
        a = 14'd0;
        exp_ld.push_back('{sel: 2'd0, row: '0, addr: a});
      end else if (i <= NUM_OUT) begin
        a = ADDR_W'(120 + (i - 1) * 120);
        exp_ld.push_back('{sel: 2'd1, row: ROW_W'(i - 1), addr: a});
      end else begin
        a = 14'd10200;
        exp_ld.push_back('{sel: 2'd2, row: '0, addr: a});
      end
      exp_rd.push_back(a);
    end
    for (int k = 0; k < NUM_OUT; k++)
      exp_wr.push_back('{addr: ADDR_W'(10284 + k), data: outval_f(ROW_W'(k))});
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_ctrl"}, 64'({busy, finished, mem_read_enable, mem_write_enable, ld_valid,
                            layer_enable, ld_sel, ld_row, out_sel}), 64'd0);
    chk({tag, "_addr_data"}, 64'({mem_address, mem_data_in}), 64'd0);
    chk({tag, "_ld_data_zero"}, 64'(ld_data != '0), 64'd0);
  endtask

  task automatic run_pass(input int fin_n, input bit hold, input int spur_at, output int done_cyc);
    int  k;
    bit  ok;
    clear_stats();
    push_pass();
    start = 1'b1;
    k  = 0;
    ok = 1'b0;
    for (int t = 0; t < 600; t++) begin
      tick();
      start = hold;
      layer_finished = 1'b0;
      if (spur_at >= 0 && st_rd == spur_at) layer_finished = 1'b1;
      if (layer_enable) begin
        k++;
        if (k == fin_n) layer_finished = 1'b1;
      end
      if (st_fin != 0) begin
        ok = 1'b1;
        break;
      end
    end
    layer_finished = 1'b0;
    if (!ok) fail_now("pass_timeout");
    chk("pass_reads",       64'(st_rd), 64'd86);
    chk("pass_loads",       64'(st_ld), 64'd86);
    chk("pass_writes",      64'(st_wr), 64'd84);
    chk("enable_cycles",    64'(st_en), 64'(fin_n));
    chk("finished_pulses",  64'(st_fin), 64'd1);
    chk("first_read_lat",   64'(first_rd - first_busy), 64'd0);
    chk("first_load_lat",   64'(first_ld - first_busy), 64'd1);
    chk("first_enable_lat", 64'(first_en - first_busy), 64'd87);
    chk("first_write_lat",  64'(first_wr - last_en), 64'd1);
    chk("finished_lat",     64'(fin_cyc - last_en), 64'd85);
    chk("busy_after_done",  64'(busy), 64'd0);
    chk("queues_drained",   64'(exp_rd.size() + exp_ld.size() + exp_wr.size()), 64'd0);
    done_cyc = fin_cyc;
  endtask

  task automatic reset_mid(input bit at_write);
    bit ok;
    clear_stats();
    push_pass();
    start = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      tick();
      start = 1'b0;
      layer_finished = layer_enable;
      if ((!at_write && st_rd == 41) || (at_write && st_wr == 20)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("reset_mid_timeout");
    layer_finished = 1'b0;
    rst = 1'b1;
    tick();
    zero_check(at_write ? "rst_at_write" : "rst_at_read");
    rst = 1'b0;
    exp_rd.delete();
    exp_ld.delete();
    exp_wr.delete();
    repeat (6) tick();
    chk("after_rst_reads",  64'(st_rd), at_write ? 64'd86 : 64'd42);
    chk("after_rst_loads",  64'(st_ld), at_write ? 64'd86 : 64'd41);
    chk("after_rst_writes", 64'(st_wr), at_write ? 64'd21 : 64'd0);
    chk("after_rst_idle",   64'(busy), 64'd0);
  endtask

  int d1, d2;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    layer_finished = 1'b0;
    clear_stats();
    repeat (3) tick();
    zero_check("reset");
    rst = 1'b0;
    tick();

    run_pass(10, 1'b0, -1, d1);   // nominal
    run_pass(1, 1'b0, -1, d1);    // finish on first compute cycle
    run_pass(4, 1'b0, 10, d1);    // spurious finish during READ

    run_pass(3, 1'b1, -1, d1);    // start held through the whole pass
    run_pass(6, 1'b0, -1, d2);
    chk("restart_gap", 64'(first_busy - d1), 64'd2);

    reset_mid(1'b0);
    run_pass(2, 1'b0, -1, d1);
    reset_mid(1'b1);
    run_pass(2, 1'b0, -1, d1);

    for (int r = 0; r < 3; r++) run_pass(int'($urandom_range(1, 30)), 1'b0, -1, d1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
